// File: rtl/mil_transmitter_if.sv
// Word handshake and line-side signals of the MIL-STD-1553 style transmitter.
interface mil_transmitter_if;
    logic        iValid;
    logic [15:0] iData;
    logic        iType;
    logic        oReady;
    logic        TXout;
    logic        nTXout;
    logic        oBusy;
    logic        oDone;

    modport master (output iValid, iData, iType,
                    input  oReady, TXout, nTXout, oBusy, oDone);
    modport slave  (input  iValid, iData, iType,
                    output oReady, TXout, nTXout, oBusy, oDone);
endinterface

// File: rtl/mil_transmitter.sv
// Manchester word transmitter: 3+3 half-bit sync, 16 data bits MSB first, odd parity.
// One-entry holding register lets the next word start with zero gap.
module mil_transmitter #(
    parameter int unsigned HALFBIT_CYCLES = 4
) (
    input  logic             clk,
    input  logic             nRst,
    mil_transmitter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SYNC, DATA, PARITY} state_t;

    state_t      state;
    logic        full;
    logic [15:0] hold_data;
    logic        hold_type;
    logic [15:0] sh;
    logic        stype;
    logic        par;
    logic [7:0]  cyc;
    logic [4:0]  hb;
    logic        tx, ntx, busy, done;
    logic        tick, last_hb, accept, xfer;

    function automatic logic [1:0] drv(input logic l);
        return {l, ~l};
    endfunction

    assign tick    = (cyc == 8'(HALFBIT_CYCLES - 1));
    assign last_hb = (state == PARITY) && (hb == 5'd1) && tick;
    assign accept  = bus.iValid && !full;
    // Transfer to the shift stage either from idle or straight off the final parity half-bit.
    assign xfer    = full && ((state == IDLE) || last_hb);

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            full      <= 1'b0;
            hold_data <= '0;
            hold_type <= 1'b0;
        end else begin
            if (accept) begin
                hold_data <= bus.iData;
                hold_type <= bus.iType;
            end
            full <= accept || (full && !xfer);
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state      <= IDLE;
            cyc        <= '0;
            hb         <= '0;
            sh         <= '0;
            stype      <= 1'b0;
            par        <= 1'b0;
            {tx, ntx}  <= 2'b00;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (xfer) begin
                state     <= SYNC;
                cyc       <= '0;
                hb        <= '0;
                sh        <= hold_data;
                stype     <= hold_type;
                par       <= ~^hold_data;
                {tx, ntx} <= drv(hold_type);
                busy      <= 1'b1;
                done      <= last_hb;
            end else if (state == IDLE) begin
                {tx, ntx} <= 2'b00;
                busy      <= 1'b0;
            end else if (!tick) begin
                cyc <= cyc + 8'd1;
            end else begin
                cyc <= '0;
                hb  <= hb + 5'd1;
                unique case (state)
                    SYNC: begin
                        if (hb == 5'd5) begin
                            state     <= DATA;
                            hb        <= '0;
                            {tx, ntx} <= drv(sh[15]);
                        end else begin
                            {tx, ntx} <= drv(hb < 5'd2 ? stype : ~stype);
                        end
                    end
                    DATA: begin
                        if (hb == 5'd31) begin
                            state     <= PARITY;
                            hb        <= '0;
                            {tx, ntx} <= drv(par);
                        end else if (!hb[0]) begin
                            {tx, ntx} <= drv(~sh[15]);
                        end else begin
                            // Second half of a bit done: move to the next bit's first half.
                            sh        <= {sh[14:0], 1'b0};
                            {tx, ntx} <= drv(sh[14]);
                        end
                    end
                    PARITY: begin
                        if (hb == 5'd0) begin
                            {tx, ntx} <= drv(~par);
                        end else begin
                            state     <= IDLE;
                            hb        <= '0;
                            {tx, ntx} <= 2'b00;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.oReady = ~full;
    assign bus.TXout  = tx;
    assign bus.nTXout = ntx;
    assign bus.oBusy  = busy;
    assign bus.oDone  = done;
endmodule

// File: tb/tb_mil_transmitter.sv
// Scoreboard bench: accepted words are queued, a negedge monitor rebuilds each word off the line.
module tb_mil_transmitter;
    localparam int H    = 4;
    localparam int WORD = 40 * H;

    typedef struct {
        logic [15:0] d;
        logic        t;
        time         ta;
    } word_t;

    logic clk  = 1'b0;
    logic nRst = 1'b0;
    mil_transmitter_if bus();

    mil_transmitter #(.HALFBIT_CYCLES(H)) dut (.clk(clk), .nRst(nRst), .bus(bus));

    always #5 clk = ~clk;

    word_t exp_q[$];
    int    n_cmp = 0;
    int    n_err = 0;
    int    mon_n = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected half-bit levels, first half-bit in bit 39.
    function automatic logic [39:0] halfbits(input logic [15:0] d, input logic t);
        logic [39:0] v;
        logic        p;
        p = ($countones(d) % 2 == 0);
        v = {34'b0, (t ? 6'b111000 : 6'b000111)};
        for (int i = 15; i >= 0; i--) v = {v[37:0], d[i], !d[i]};
        v = {v[37:0], p, !p};
        return v;
    endfunction

    initial begin
        word_t       cur;
        logic [39:0] exp_v, act_v;
        logic        stable, exp_done, chk_cont, cont_exp, prev_busy;
        logic        samp[WORD];
        exp_done = 0; chk_cont = 0; cont_exp = 0; prev_busy = 0;
        forever begin
            @(negedge clk);
            if (!nRst) begin
                mon_n = 0; exp_done = 0; chk_cont = 0; prev_busy = 0;
                continue;
            end
            check("done_pulse", bus.oDone, exp_done);
            exp_done = 0;
            if (chk_cont) begin
                check("back_to_back", bus.oBusy, cont_exp);
                chk_cont = 0;
            end
            if (bus.oBusy) begin
                check("complement", bus.nTXout, !bus.TXout);
                if (mon_n == 0) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_word", exp_q.size(), 1);
                        cur = '{16'h0, 1'b0, $time};
                    end else begin
                        cur = exp_q.pop_front();
                    end
                    if (!prev_busy) check("start_latency", ($time - cur.ta) <= 20, 1);
                end
                samp[mon_n] = bus.TXout;
                mon_n++;
                if (mon_n == WORD) begin
                    exp_v  = halfbits(cur.d, cur.t);
                    stable = 1;
                    for (int k = 0; k < 40; k++) begin
                        act_v[39-k] = samp[k*H];
                        for (int j = 0; j < H; j++)
                            if (samp[k*H+j] !== act_v[39-k]) stable = 0;
                    end
                    check($sformatf("wave_%04h_t%0d", cur.d, cur.t), {stable, act_v}, {1'b1, exp_v});
                    mon_n    = 0;
                    exp_done = 1;
                    chk_cont = 1;
                    cont_exp = (exp_q.size() > 0) && (exp_q[0].ta < $time);
                end
            end else begin
                check("idle_line", {bus.TXout, bus.nTXout}, 2'b00);
                if (mon_n != 0) begin
                    check("word_truncated", mon_n, WORD);
                    mon_n = 0;
                end
            end
            prev_busy = bus.oBusy;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [15:0] d, input logic t, input bit keep);
        int w = 0;
        bus.iValid = 1'b1;
        bus.iData  = d;
        bus.iType  = t;
        while (!bus.oReady && w < 1000) begin
            @(posedge clk); #1; w++;
        end
        if (!bus.oReady) begin
            check("ready_timeout", bus.oReady, 1);
            bus.iValid = 1'b0;
            return;
        end
        @(posedge clk);
        exp_q.push_back('{d, t, $time});
        #1;
        check("ready_after_accept", bus.oReady, 0);
        if (!keep) bus.iValid = 1'b0;
    endtask

    task automatic wait_idle();
        int w = 0;
        while ((exp_q.size() != 0 || mon_n != 0 || bus.oBusy) && w < 3000) begin
            @(posedge clk); #1; w++;
        end
        check("drain_timeout", w < 3000, 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        bus.iValid = 1'b0;
        bus.iData  = '0;
        bus.iType  = 1'b0;
        #12;
        check("rst_ready", bus.oReady, 1);
        check("rst_tx",    bus.TXout,  0);
        check("rst_ntx",   bus.nTXout, 0);
        check("rst_busy",  bus.oBusy,  0);
        check("rst_done",  bus.oDone,  0);
        @(posedge clk); #3 nRst = 1'b1;
        @(posedge clk); #1;

        send(16'h0000, 1'b1, 0); wait_idle();
        send(16'hFFFF, 1'b0, 0); wait_idle();
        send(16'h1234, 1'b1, 0); wait_idle();
        send(16'hA5A5, 1'b1, 0); send(16'h0001, 1'b0, 0); wait_idle();

        // Abort mid-word with a second word held.
        send(16'hBEEF, 1'b1, 0); send(16'h5555, 1'b0, 0);
        repeat (20 * H - 1) @(posedge clk);
        #2 nRst = 1'b0;
        #1;
        check("arst_tx",    bus.TXout,  0);
        check("arst_ntx",   bus.nTXout, 0);
        check("arst_ready", bus.oReady, 1);
        check("arst_busy",  bus.oBusy,  0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #3 nRst = 1'b1;
        repeat (200) @(posedge clk);
        #1;
        check("post_rst_ready", bus.oReady, 1);

        for (int i = 0; i < 6; i++)
            send(16'($urandom), 1'($urandom_range(0, 1)), i < 5);
        wait_idle();

        for (int i = 0; i < 8; i++) begin
            int g;
            send(16'($urandom), 1'($urandom_range(0, 1)), 0);
            g = $urandom_range(0, 200);
            repeat (g) begin
                @(posedge clk); #1;
            end
        end
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mil_transmitter.md
MIL_TRANSMITTER -- requirements
Module: mil_transmitter

Interface
REQ-001 Parameter HALFBIT_CYCLES, default 4: clk cycles per half-bit time (500 ns); legal range 2..255.
REQ-002 Port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 Port nRst  input  1  asynchronous reset, active low.
REQ-004 Port iValid  input  1  word offered for transmission.
REQ-005 Port iData  input  16  word payload, transmitted MSB first.
REQ-006 Port iType  input  1  sync type: 1 = command/status sync, 0 = data sync.
REQ-007 Port oReady  output  1  holding register empty; a word is accepted on a rising edge where iValid and oReady are both 1.
REQ-008 Port TXout  output  1  positive line phase.
REQ-009 Port nTXout  output  1  negative line phase.
REQ-010 Port oBusy  output  1  high while a word is on the line.
REQ-011 Port oDone  output  1  one-cycle pulse after the last parity half-bit of each word.

Function
REQ-012 The block SHALL contain a one-entry holding register (data + type + full flag) and a shift stage; oReady = NOT full.
REQ-013 Acceptance SHALL set full and capture iData/iType; iData/iType are ignored when oReady is 0.
REQ-014 States SHALL be IDLE, SYNC, DATA, PARITY; a half-bit tick SHALL occur every HALFBIT_CYCLES cycles, counted from state entry.
REQ-015 IDLE -> SYNC on the edge after full is seen, transferring the holding register to the shift stage and clearing full in the same edge.
REQ-016 SYNC lasts 6 half-bits: type 1 drives TXout=1 for 3 half-bits then 0 for 3; type 0 the inverse.
REQ-017 DATA lasts 32 half-bits: bit 1 = high then low, bit 0 = low then high, bit 15 first.
REQ-018 PARITY lasts 2 half-bits, encoded like a data bit; parity SHALL be odd, i.e. the XNOR of the 16 data bits.
REQ-019 Total word time SHALL be exactly 40 * HALFBIT_CYCLES cycles.
REQ-020 While oBusy=1, nTXout SHALL equal NOT TXout every cycle.
REQ-021 In IDLE, TXout and nTXout SHALL both be 0 (bus released), and oBusy SHALL be 0.
REQ-022 At the end of PARITY, if full=1, the FSM SHALL go directly to SYNC with the held word, with zero gap cycles; otherwise it returns to IDLE.
REQ-023 oDone SHALL pulse on the cycle after the final PARITY half-bit in both cases of REQ-022.
REQ-024 Acceptance during transmission SHALL be allowed, fills the holding register, and SHALL NOT disturb the word on the line.
REQ-025 Acceptance on the same edge as transfer from holding register to shift stage SHALL be honoured: full stays 1 with the new word.
REQ-026 Outputs TXout, nTXout, oBusy, oDone SHALL be registered, with no combinational path from inputs.
REQ-027 First line transition after acceptance in IDLE SHALL occur within 2 clk cycles.

Reset
REQ-028 nRst low SHALL immediately force: state IDLE, full=0, oReady=1, TXout=0, nTXout=0, oBusy=0, oDone=0, and counters 0.
REQ-029 Reset asserted mid-word SHALL abort the word and drop any held word; after release the line stays idle until a new acceptance.
REQ-030 Outputs SHALL follow REQ-028 from the first edge after nRst deasserts until an acceptance occurs.

Verification
REQ-031 iData=0x0000, iType=1, HALFBIT_CYCLES=4 -> TXout high 12 cycles, then low 12, then 16 x (low 4, high 4), then parity 1 (high 4, low 4); oDone once at cycle 160+.
REQ-032 iData=0xFFFF, iType=0 -> sync low 12 then high 12, 16 x (high 4, low 4), parity 1 = high then low; nTXout always complementary while oBusy.
REQ-033 Two words 0xA5A5 (type 1), then 0x0001 (type 0) offered back-to-back -> second accepted during first; 80 contiguous half-bits, no idle cycle between; two oDone pulses 160 cycles apart.
REQ-034 Word 0x1234 where parity must be 0 (popcount 5 is odd) -> parity half-bits low then high.
REQ-035 nRst pulsed low at half-bit 20 with a held word pending -> TXout=nTXout=0, oReady=1 asynchronously; no further line activity after release.
REQ-036 iValid held high continuously with changing iData -> each accepted word appears exactly once in order; oReady low whenever the holding register is full.
